// File: rtl/mem_responder_if.sv
// Request/response bundle between a requester and mem_responder.
// The requester drives the request fields; the responder drives completion status.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory with fixed-latency handshake (IDLE/WAIT/RESP).
// Define MEM_RESPONDER_BYTE_EN to make writes honour the be lane enables.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, nxt;
  logic [3:0]  cnt;
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH];

  logic        a_we, a_err, take, commit;
  logic [31:0] a_addr, a_wdata;
  logic [AW-1:0] a_idx;

`ifdef MEM_RESPONDER_BYTE_EN
  logic [3:0]  be_q, a_be;
`else
  logic        unused_be;
  assign unused_be = ^bus.be;
`endif

  // Attributes of the access being launched: live bus in IDLE, captured copy later.
  always_comb begin
    a_we    = (state == IDLE) ? bus.we    : we_q;
    a_addr  = (state == IDLE) ? bus.addr  : addr_q;
    a_wdata = (state == IDLE) ? bus.wdata : wdata_q;
`ifdef MEM_RESPONDER_BYTE_EN
    a_be    = (state == IDLE) ? bus.be    : be_q;
`endif
  end

  assign a_err  = (a_addr[1:0] != 2'b00) || (a_addr >= LIMIT);
  assign a_idx  = a_addr[AW+1:2];
  assign take   = (state == IDLE) && bus.req;
  assign commit = reset && (nxt == RESP) && (state != RESP)
                  && a_we && !a_err;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.req) nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ack   = 1'b0;
    bus.err   = 1'b0;
    bus.rdata = '0;
    bus.busy  = (state != IDLE);
    if (state == RESP && reset) begin
      bus.ack   = 1'b1;
      bus.err   = err_q;
      bus.rdata = (!we_q && !err_q) ? mem[addr_q[AW+1:2]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_RESPONDER_BYTE_EN
      be_q    <= '0;
`endif
    end else if (take) begin
      cnt     <= 4'(WAIT_CYCLES);
      we_q    <= bus.we;
      err_q   <= a_err;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
`ifdef MEM_RESPONDER_BYTE_EN
      be_q    <= bus.be;
`endif
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit) begin
`ifdef MEM_RESPONDER_BYTE_EN
      for (int i = 0; i < 4; i++)
        if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
`else
      mem[a_idx] <= a_wdata;
`endif
    end
  end
endmodule
